// File: rtl/icache_rsp.sv
`default_nettype none
// icache_rsp: direct-mapped read-only instruction cache. Hits answer on the next cycle.
// Misses stall fetch and refill the whole line, word 0 first, from backing memory.
module icache_rsp #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  input  logic [31:0] i_req_addr,
  input  logic        i_flush,
  input  logic        i_inval,
  output logic        o_rsp_vld,
  output logic [31:0] o_rsp_inst,
  output logic        o_busy,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
);

  localparam int OW = $clog2(WORDS);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - OW - IW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     req_word_q, req_word_d;
  logic [OW-1:0]   beat_q, beat_d;
  logic            drop_q, drop_d;
  logic            inval_pend_q, inval_pend_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [31:0]     rsp_inst_q, rsp_inst_d;

  logic [LINES-1:0] valid_q;
  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [LINES*WORDS];

  logic            fill_we;
  logic            line_set;
  logic            inval_all;

  logic [OW-1:0]   w_req_off;
  logic [IW-1:0]   w_req_idx;
  logic [TW-1:0]   w_req_tag;
  logic            w_hit;
  logic [OW-1:0]   w_fill_off;
  logic [IW-1:0]   w_fill_idx;
  logic [TW-1:0]   w_fill_tag;
  logic            w_unused;

  assign w_req_off  = i_req_addr[2+OW-1:2];
  assign w_req_idx  = i_req_addr[2+OW+IW-1:2+OW];
  assign w_req_tag  = i_req_addr[31:2+OW+IW];
  assign w_hit      = valid_q[w_req_idx] && (tag_q[w_req_idx] == w_req_tag);
  assign w_unused   = ^i_req_addr[1:0];

  assign w_fill_off = req_word_q[OW-1:0];
  assign w_fill_idx = req_word_q[OW+IW-1:OW];
  assign w_fill_tag = req_word_q[29:OW+IW];

  always_comb begin
    state_d      = state_q;
    req_word_d   = req_word_q;
    beat_d       = beat_q;
    drop_d       = drop_q;
    inval_pend_d = inval_pend_q;
    rsp_vld_d    = 1'b0;
    rsp_inst_d   = rsp_inst_q;
    o_busy       = 1'b0;
    o_mem_ren    = 1'b0;
    o_mem_addr   = 32'h0;
    fill_we      = 1'b0;
    line_set     = 1'b0;
    inval_all    = 1'b0;

    case (state_q)
      IDLE: begin
        // The hit lookup above uses the valid bits before this cycle's invalidate.
        inval_all = i_inval;
        if (i_req_vld && !i_flush) begin
          if (w_hit) begin
            rsp_vld_d  = 1'b1;
            rsp_inst_d = data_q[{w_req_idx, w_req_off}];
          end else begin
            o_busy       = 1'b1;
            req_word_d   = i_req_addr[31:2];
            beat_d       = '0;
            drop_d       = 1'b0;
            inval_pend_d = 1'b0;
            state_d      = FILL;
          end
        end
      end

      FILL: begin
        o_busy     = 1'b1;
        o_mem_ren  = 1'b1;
        o_mem_addr = {req_word_q[29:OW], beat_q, 2'b00};
        if (i_flush) drop_d = 1'b1;
        if (i_inval) inval_pend_d = 1'b1;
        if (i_mem_valid) begin
          fill_we = 1'b1;
          beat_d  = beat_q + OW'(1);
          if (beat_q == OW'(WORDS - 1)) begin
            line_set = 1'b1;
            state_d  = RESP;
          end
        end
      end

      RESP: begin
        o_busy = 1'b1;
        if (!drop_q && !i_flush) begin
          rsp_vld_d  = 1'b1;
          rsp_inst_d = data_q[{w_fill_idx, w_fill_off}];
        end
        // A deferred invalidate also wipes the line that was just filled.
        inval_all    = inval_pend_q | i_inval;
        inval_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      req_word_q   <= '0;
      beat_q       <= '0;
      drop_q       <= 1'b0;
      inval_pend_q <= 1'b0;
      rsp_vld_q    <= 1'b0;
      rsp_inst_q   <= 32'h0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      req_word_q   <= req_word_d;
      beat_q       <= beat_d;
      drop_q       <= drop_d;
      inval_pend_q <= inval_pend_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_inst_q   <= rsp_inst_d;
      if (inval_all) valid_q <= '0;
      else if (line_set) valid_q[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (fill_we) data_q[{w_fill_idx, beat_q}] <= i_mem_rdata;
    if (line_set) tag_q[w_fill_idx] <= w_fill_tag;
  end

  assign o_rsp_vld  = rsp_vld_q;
  assign o_rsp_inst = rsp_inst_q;

endmodule
`default_nettype wire

// File: doc/icache_rsp.md
Name: icache_rsp

Overview:
- Direct-mapped, read-only instruction cache that answers the fetch stage's instruction read requests.
- Takes a word address each cycle and returns the instruction word.
- On a hit, responds one cycle later. On a miss, stalls the fetch stage via o_busy, fills the whole line from backing memory one word per beat, then responds.
- Sits between the fetch stage's instruction read address and the backing instruction memory.

Parameters:
- LINES, 16, number of cache lines; power of two, ≥2.
- WORDS, 4, 32-bit words per line; power of two, ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req_vld  in  1  fetch request valid this cycle.
- i_req_addr  in  32  instruction byte address; bits [1:0] ignored.
- i_flush  in  1  fetch redirect; cancels pending response.
- i_inval  in  1  invalidate all lines (fence.i).
- o_rsp_vld  out  1  o_rsp_inst valid this cycle.
- o_rsp_inst  out  32  instruction word.
- o_busy  out  1  stall to fetch; drives its hold input.
- o_mem_ren  out  1  backing-memory read request, held until accepted.
- o_mem_addr  out  32  word-aligned backing-memory address.
- i_mem_valid  in  1  backing-memory data valid / request accepted.
- i_mem_rdata  in  32  backing-memory read data.

Behaviour:
- Reset and signal names:
  - Interface as decided: reset i_rst, synchronous, active-high; clock i_clk.
  - Reset clears all valid bits and sets state IDLE.
  - Reset drives o_rsp_vld=0, o_rsp_inst=0, o_busy=0, o_mem_ren=0, o_mem_addr=0.
  - Reset mid-fill abandons the fill; the line stays invalid.
- Address split:
  - off = addr[2+log2(WORDS)-1:2].
  - idx = next log2(LINES) bits.
  - tag = remaining upper bits.
  - Storage per line: valid bit, tag, WORDS data words.
- Hit condition: valid[idx] & tag match, evaluated combinationally on i_req_addr.
- States: IDLE, FILL, RESP.
- IDLE:
  - i_req_vld & hit & !i_flush: next cycle o_rsp_vld=1, o_rsp_inst=data[idx][off]. Back-to-back hits give one response per cycle.
  - i_req_vld & miss & !i_flush: o_busy=1 combinationally in that cycle, latch address (req_addr_q), go to FILL with beat counter=0, drop flag=0.
  - i_flush in the same cycle as i_req_vld: request ignored, no response, no fill.
- FILL:
  - o_busy=1.
  - o_mem_ren=1, o_mem_addr = {req_addr_q line base, beat counter, 2'b00}.
  - Address is held stable until i_mem_valid=1.
  - On i_mem_valid: write i_mem_rdata into word[beat] and increment beat. The next beat's address is presented the following cycle.
  - i_mem_valid while o_mem_ren=0 is ignored.
  - After beat WORDS-1 is written: set valid and tag for the line, go to RESP.
  - Fill order is always word 0 to WORDS-1 (no critical-word-first).
  - i_flush during FILL sets drop=1. The fill still completes so the line is consistent.
- RESP:
  - o_busy=1 in this cycle.
  - Next cycle: o_rsp_vld = !drop with o_rsp_inst = requested word; state returns to IDLE.
  - o_busy=0 from the response cycle.
  - i_flush in the RESP cycle also suppresses the response.
- Latency:
  - Hit: 1 cycle.
  - Miss: 1 + (sum of beat waits) + 1 cycles.
- o_rsp_vld is a single-cycle pulse; o_rsp_inst holds its last value otherwise.
- Invalidate:
  - i_inval in IDLE clears all valid bits at the clock edge. A same-cycle request is evaluated against the pre-clear state.
  - i_inval during FILL or RESP is recorded and applied on return to IDLE, including to the just-filled line.
- Simultaneous events: reset > i_flush > request.
- No writes from the fetch side. Index wrap-around aliases by tag only.

Test Plan:
- Cold miss (LINES=16, WORDS=4): request 0x0000_0040. Required response:
  - o_busy=1 from the request cycle.
  - o_mem_addr sequence 0x40, 0x44, 0x48, 0x4C, each held until i_mem_valid.
  - Backing memory returns 0x1111_0000+n per beat n.
  - Response 0x1111_0000 after the RESP cycle, then o_busy=0.
- Hit streaming after the fill: requests 0x44, 0x48, 0x4C on consecutive cycles -> o_rsp_vld=1 on three consecutive cycles with 0x1111_0001, 0x1111_0002, 0x1111_0003. No o_mem_ren.
- Conflict miss: after filling 0x40, request 0x0000_0140 (same idx, different tag) -> refill at 0x140..0x14C. A subsequent request for 0x40 misses again.
- Flush mid-fill: i_flush on the second beat -> all 4 beats still complete, no o_rsp_vld. A later request for the same address hits in 1 cycle.
- Invalidate: fill line 0x40, pulse i_inval in IDLE -> the next request for 0x40 misses. i_inval during a fill -> the filled line is invalid afterwards.
- Reset mid-fill (after beat 1): o_mem_ren=0 and o_busy=0 the cycle after reset. A request for the same address misses, and its fill restarts at word 0.
